// File: rtl/reg_d_pkg.sv
// Shared widths, types and reset value for the reg_d register file.
package reg_d_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREGS  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam data_t RST_VAL = data_t'(0);

endpackage

// File: rtl/reg_d_if.sv
// Register-file access bus: write port plus two read ports.
interface reg_d_if;
  import reg_d_pkg::*;

  logic  regwrite;
  addr_t ra1;
  addr_t ra2;
  addr_t wa;
  data_t wd;
  data_t rd1;
  data_t rd2;

  modport master (
    output regwrite, ra1, ra2, wa, wd,
    input  rd1, rd2
  );

  modport slave (
    input  regwrite, ra1, ra2, wa, wd,
    output rd1, rd2
  );

endinterface

// File: rtl/reg_d_rdport.sv
// One combinational read port of the register file.
// Optional build macro: REGD_WRITE_BYPASS_EN forwards the in-flight write data
// when the read address matches the write address.
module reg_d_rdport
  import reg_d_pkg::*;
(
  input  data_t regs [NREGS],
  input  addr_t addr,
`ifdef REGD_WRITE_BYPASS_EN
  input  logic  byp_en,
  input  addr_t wa,
  input  data_t wd,
`endif
  output data_t rd
);

  // Address mux, overridden by pending write data when forwarding is built in.
  always_comb begin
    rd = regs[addr];
`ifdef REGD_WRITE_BYPASS_EN
    if (byp_en && (addr == wa)) begin
      rd = wd;
    end
`endif
  end

endmodule

// File: rtl/reg_d.sv
// 8 x 8 register file: two combinational read ports, one synchronous write port.
// Optional build macro: REGD_WRITE_BYPASS_EN enables write-first forwarding on
// both read ports; storage and write timing are unchanged.
module reg_d
  import reg_d_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  reg_d_if.slave   bus
);

  data_t regs [NREGS];

  // Storage: synchronous reset has priority over the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= RST_VAL;
      end
    end else if (bus.regwrite) begin
      regs[bus.wa] <= bus.wd;
    end
  end

`ifdef REGD_WRITE_BYPASS_EN
  logic byp_en;
  assign byp_en = bus.regwrite & ~rst;
`endif

  reg_d_rdport u_rdport1 (
    .regs   (regs),
    .addr   (bus.ra1),
`ifdef REGD_WRITE_BYPASS_EN
    .byp_en (byp_en),
    .wa     (bus.wa),
    .wd     (bus.wd),
`endif
    .rd     (bus.rd1)
  );

  reg_d_rdport u_rdport2 (
    .regs   (regs),
    .addr   (bus.ra2),
`ifdef REGD_WRITE_BYPASS_EN
    .byp_en (byp_en),
    .wa     (bus.wa),
    .wd     (bus.wd),
`endif
    .rd     (bus.rd2)
  );

endmodule

// File: tb/tb_reg_d.sv
// Self-checking bench for reg_d: directed cases followed by random traffic
// compared against an array model of the register contents.
module tb_reg_d;
  import reg_d_pkg::*;

  logic clk;
  logic rst;

  reg_d_if bus ();

  reg_d dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  data_t model [NREGS];
  logic  cur_rst;
  logic  cur_we;
  addr_t cur_wa;
  data_t cur_wd;

  task automatic check(input string tag, input data_t obs, input data_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value a read port should show given the current inputs and model contents.
  function automatic data_t exp_rd(input addr_t a);
`ifdef REGD_WRITE_BYPASS_EN
    if (cur_we === 1'b1 && cur_rst === 1'b0 && a === cur_wa) return cur_wd;
`endif
    return model[a];
  endfunction

  task automatic drive(input logic r, input logic we, input addr_t wa, input data_t wd,
                       input addr_t a1, input addr_t a2);
    cur_rst = r;  cur_we = we;  cur_wa = wa;  cur_wd = wd;
    rst = r;
    bus.regwrite = we;
    bus.wa  = wa;
    bus.wd  = wd;
    bus.ra1 = a1;
    bus.ra2 = a2;
  endtask

  // One rising edge; model follows the reset/write rules, then settle 1 unit.
  task automatic edge_step();
    @(posedge clk);
    if (cur_rst) begin
      for (int i = 0; i < int'(NREGS); i++) model[i] = RST_VAL;
    end else if (cur_we) begin
      model[cur_wa] = cur_wd;
    end
    #1;
  endtask

  task automatic check_ports(input string tag);
    #1;
    check({tag, "_rd1"}, bus.rd1, exp_rd(bus.ra1));
    check({tag, "_rd2"}, bus.rd2, exp_rd(bus.ra2));
  endtask

  initial begin
    for (int i = 0; i < int'(NREGS); i++) model[i] = 8'hxx;
    drive(1'b1, 1'b0, 3'd0, 8'd0, 3'd0, 3'd0);
    #2;

    // Reset: every register reads zero on both ports.
    edge_step();
    drive(1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 3'd0);
    for (int i = 0; i < int'(NREGS); i++) begin
      bus.ra1 = addr_t'(i);
      bus.ra2 = addr_t'(NREGS - 1 - i);
      #1;
      check("reset_rd1", bus.rd1, 8'h00);
      check("reset_rd2", bus.rd2, 8'h00);
    end

    // Disabled write leaves register 3 untouched.
    drive(1'b0, 1'b0, 3'd3, 8'd7, 3'd3, 3'd3);
    edge_step();
    #1;
    check("wr_disabled", bus.rd1, 8'h00);

    // Write 2 into register 4; register 1 unaffected.
    drive(1'b0, 1'b1, 3'd4, 8'd2, 3'd1, 3'd1);
    edge_step();
    drive(1'b0, 1'b0, 3'd0, 8'd0, 3'd4, 3'd4);
    #1;
    check("wr4_rd1", bus.rd1, 8'd2);
    check("wr4_rd2", bus.rd2, 8'd2);
    bus.ra1 = 3'd1;
    bus.ra2 = 3'd1;
    #1;
    check("other_rd1", bus.rd1, 8'd0);
    check("other_rd2", bus.rd2, 8'd0);

    // Overwrite register 4 with 23.
    drive(1'b0, 1'b1, 3'd4, 8'd23, 3'd0, 3'd0);
    edge_step();
    drive(1'b0, 1'b0, 3'd0, 8'd0, 3'd4, 3'd0);
    #1;
    check("overwrite_rd1", bus.rd1, 8'd23);
    check("overwrite_rd2", bus.rd2, 8'd0);

    // Reset beats a simultaneous write.
    drive(1'b1, 1'b1, 3'd5, 8'hAA, 3'd5, 3'd4);
    edge_step();
    drive(1'b0, 1'b0, 3'd0, 8'd0, 3'd5, 3'd4);
    #1;
    check("rst_prio_rd1", bus.rd1, 8'h00);
    check("rst_prio_rd2", bus.rd2, 8'h00);

    // Read-during-write on register 6.
    drive(1'b0, 1'b1, 3'd6, 8'h11, 3'd0, 3'd0);
    edge_step();
    drive(1'b0, 1'b1, 3'd6, 8'h3C, 3'd6, 3'd6);
    #1;
`ifdef REGD_WRITE_BYPASS_EN
    check("rdw_pre_rd1", bus.rd1, 8'h3C);
`else
    check("rdw_pre_rd1", bus.rd1, 8'h11);
`endif
    edge_step();
    check("rdw_post_rd1", bus.rd1, 8'h3C);
    check("rdw_post_rd2", bus.rd2, 8'h3C);

    // X on idle write inputs must not disturb storage.
    drive(1'b0, 1'b0, 3'bxxx, 8'hxx, 3'd6, 3'd4);
    edge_step();
    for (int i = 0; i < int'(NREGS); i++) begin
      bus.ra1 = addr_t'(i);
      #1;
      check("idle_x", bus.rd1, model[i]);
    end

    // Back-to-back writes to one address: last one wins.
    drive(1'b0, 1'b1, 3'd2, 8'h5A, 3'd2, 3'd2);
    edge_step();
    drive(1'b0, 1'b1, 3'd2, 8'hC3, 3'd2, 3'd2);
    edge_step();
    drive(1'b0, 1'b0, 3'd0, 8'd0, 3'd2, 3'd2);
    #1;
    check("b2b_rd1", bus.rd1, 8'hC3);

    // Random traffic against the model, checked before and after each edge.
    for (int n = 0; n < 300; n++) begin
      logic  r, we;
      addr_t wa, a1, a2;
      data_t wd;
      r  = ($urandom_range(0, 19) == 0);
      we = $urandom_range(0, 1) == 1;
      wa = addr_t'($urandom_range(0, NREGS - 1));
      wd = data_t'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? wa : addr_t'($urandom_range(0, NREGS - 1));
      a2 = ($urandom_range(0, 3) == 0) ? wa : addr_t'($urandom_range(0, NREGS - 1));
      drive(r, we, wa, wd, a1, a2);
      check_ports("rand_pre");
      edge_step();
      check_ports("rand_post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
